video_fetch: RTL

Raster video fetch and pixel serialiser for the Z80 emulator. It sits downstream of the horizontal line counter, consuming its `low_bits` phase and `term_cnt` line-end pulse. It steals one SRAM read slot per 32-clock character period, while the CPU clock phase (`h_low[0]`) is low, and serialises the fetched bytes into a 1-bpp pixel stream with vertical sync and frame timing.

---
 rtl/video_fetch.sv | 134 +++++++++++++
 1 files changed

// File: rtl/video_fetch.sv
// Raster video fetch and 1-bpp pixel serialiser: steals one SRAM read per
// 32-clock character slot and shifts the fetched byte out over the next slot.
module video_fetch #(
   parameter int          BYTES_PER_LINE = 32,
   parameter int          LINES_ACTIVE   = 192,
   parameter int          LINES_TOTAL    = 262,
   parameter int          VSYNC_START    = 224,
   parameter int          VSYNC_LEN      = 3,
   parameter logic [14:0] BASE_ADDR      = 15'h6000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [4:0]  h_low,
   input  logic        h_end,
   input  logic [7:0]  vid_d,
   output logic [14:0] vid_addr,
   output logic        vid_rd_n,
   output logic        pixel,
   output logic        active,
   output logic        vsync_n,
   output logic        frame_start
);

   logic [8:0]  line_q, line_d;
   logic [4:0]  col_q, col_d;
   logic        col_done_q, col_done_d;
   logic [14:0] line_base_q, line_base_d;
   logic        fetch_q, fetch_d;
   logic [7:0]  shift_q, shift_d;
   logic        shift_v_q, shift_v_d;
   logic        rd_n_q, rd_n_d;
   logic [14:0] addr_q, addr_d;
   logic        pixel_q, pixel_d;
   logic        active_q, active_d;
   logic        vsync_n_q, vsync_n_d;
   logic        frame_start_q, frame_start_d;

   logic        line_active;
   logic        fetch_go;

   always_comb begin
      line_active = line_q < 9'(LINES_ACTIVE);
      // col_done marks a slot counter pushed past 31, so the saturated count
      // never re-fetches the last byte in long lines.
      fetch_go = !h_end && (h_low == 5'd29) && line_active && !col_done_q &&
                 ({1'b0, col_q} < 6'(BYTES_PER_LINE));

      line_d        = line_q;
      col_d         = col_q;
      col_done_d    = col_done_q;
      line_base_d   = line_base_q;
      fetch_d       = 1'b0;
      shift_d       = shift_q;
      shift_v_d     = shift_v_q;
      frame_start_d = 1'b0;

      if (h_end) begin
         col_d      = 5'd0;
         col_done_d = 1'b0;
         shift_v_d  = 1'b0;
         if (line_q == 9'(LINES_TOTAL - 1)) begin
            line_d        = 9'd0;
            line_base_d   = BASE_ADDR;
            frame_start_d = 1'b1;
         end else begin
            line_d = line_q + 9'd1;
            if (line_active) line_base_d = line_base_q + 15'(BYTES_PER_LINE);
         end
      end else begin
         fetch_d = (h_low == 5'd30) && !rd_n_q;
         if (h_low == 5'd31) begin
            if (col_q == 5'd31) col_done_d = 1'b1;
            else                col_d      = col_q + 5'd1;
            // The fetched byte lands straight in the shifter on the capture
            // edge so its first pixel shows at h_low==0 of the next slot.
            if (fetch_q) begin
               shift_d   = vid_d;
               shift_v_d = 1'b1;
            end else begin
               shift_v_d = 1'b0;
            end
         end else if (h_low[1:0] == 2'd3) begin
            shift_d = {shift_q[6:0], 1'b0};
         end
      end

      rd_n_d    = !fetch_go;
      addr_d    = fetch_go ? (line_base_q + {10'd0, col_q}) : addr_q;
      pixel_d   = shift_d[7] & shift_v_d;
      active_d  = shift_v_d;
      vsync_n_d = !(({1'b0, line_d} >= 10'(VSYNC_START)) &&
                    ({1'b0, line_d} <  10'(VSYNC_START + VSYNC_LEN)));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         line_q        <= 9'd0;
         col_q         <= 5'd0;
         col_done_q    <= 1'b0;
         line_base_q   <= BASE_ADDR;
         fetch_q       <= 1'b0;
         shift_q       <= 8'd0;
         shift_v_q     <= 1'b0;
         rd_n_q        <= 1'b1;
         addr_q        <= BASE_ADDR;
         pixel_q       <= 1'b0;
         active_q      <= 1'b0;
         vsync_n_q     <= 1'b1;
         frame_start_q <= 1'b0;
      end else begin
         line_q        <= line_d;
         col_q         <= col_d;
         col_done_q    <= col_done_d;
         line_base_q   <= line_base_d;
         fetch_q       <= fetch_d;
         shift_q       <= shift_d;
         shift_v_q     <= shift_v_d;
         rd_n_q        <= rd_n_d;
         addr_q        <= addr_d;
         pixel_q       <= pixel_d;
         active_q      <= active_d;
         vsync_n_q     <= vsync_n_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign vid_addr    = addr_q;
   assign vid_rd_n    = rd_n_q;
   assign pixel       = pixel_q;
   assign active      = active_q;
   assign vsync_n     = vsync_n_q;
   assign frame_start = frame_start_q;

endmodule
